// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, NOP encoding and response record for the instruction fetch unit
package imem_pkg;
  localparam int INSTR_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [INSTR_W-1:0] IMEM_NOP = 32'h0000_0000;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic fault;
  } rsp_t;
endpackage

// File: rtl/imem_if.sv
// imem_if: fetch request/response handshake bundle
//   req_valid/req_ready/req_addr : fetch request channel (byte address)
//   rsp_valid/rsp_ready          : response channel handshake
//   rsp_instr/rsp_fault          : fetched word and misaligned/out-of-range flag
interface imem_if;
  import imem_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [31:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [INSTR_W-1:0] rsp_instr;
  logic rsp_fault;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_instr, rsp_fault);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_instr, rsp_fault);
endinterface

// File: rtl/imem_resp_stage.sv
// imem_resp_stage: one stallable valid/data pipeline register
//   en       : stage may load (downstream has room or stage is empty)
//   in_*     : upstream valid and response record
//   out_*    : registered valid and response record
module imem_resp_stage
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  input  rsp_t in_data,
  output logic out_valid,
  output rsp_t out_data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: byte-programmable instruction memory with a LATENCY-deep stallable fetch pipeline
//   clk, rst                       : clock, synchronous active-high reset
//   bus (imem_if.slave)            : fetch request / response handshake
//   prog_we, prog_addr, prog_data  : program-load byte write port
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY = 1,
  parameter int BIG_ENDIAN = 1
) (
  input  logic clk,
  input  logic rst,
  imem_if.slave bus,
  input  logic prog_we,
  input  logic [31:0] prog_addr,
  input  logic [BYTE_W-1:0] prog_data
);
  localparam int AW = $clog2(DEPTH_BYTES);
  logic [BYTE_W-1:0] mem [DEPTH_BYTES];
  logic v [LATENCY+1];
  logic en [LATENCY+1];
  rsp_t d [LATENCY+1];
  logic fault;
  logic [AW-1:0] idx;
  logic [INSTR_W-1:0] word;
  // range check on the full 32-bit address first, so the narrow index below can never wrap
  assign fault = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > 32'(DEPTH_BYTES - 4));
  assign idx = bus.req_addr[AW-1:0];
  always_comb begin
    word = IMEM_NOP;
    if (!fault)
      word = (BIG_ENDIAN != 0)
        ? {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]}
        : {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
  end
  always_ff @(posedge clk) begin
    if (prog_we && prog_addr < 32'(DEPTH_BYTES)) mem[prog_addr[AW-1:0]] <= prog_data;
  end
  // en[0] is low only when every stage holds a response and the consumer stalls
  assign bus.req_ready = !rst && !prog_we && en[0];
  assign v[0] = bus.req_valid && bus.req_ready;
  assign d[0] = '{instr: word, fault: fault};
  assign en[LATENCY] = bus.rsp_ready;
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    assign en[k] = !v[k+1] || en[k+1];
    imem_resp_stage u_stage (
      .clk(clk),
      .rst(rst),
      .en(en[k]),
      .in_valid(v[k]),
      .in_data(d[k]),
      .out_valid(v[k+1]),
      .out_data(d[k+1])
    );
  end
  assign bus.rsp_valid = v[LATENCY];
  assign bus.rsp_instr = d[LATENCY].instr;
  assign bus.rsp_fault = d[LATENCY].fault;
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: scoreboard bench over three configurations (L1/BE, L1/LE, L2/BE)
module tb_imem_fetch;
  typedef struct packed {
    logic [1:0] dut;
    logic [31:0] instr;
    logic fault;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic req_valid [3];
  logic [31:0] req_addr [3];
  logic rsp_ready [3];
  logic req_ready [3];
  logic rsp_valid [3];
  logic [31:0] rsp_instr [3];
  logic rsp_fault [3];
  exp_t exp_q [$];
  int nvec = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : dut
    imem_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_addr = req_addr[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g] = bus.req_ready;
    assign rsp_valid[g] = bus.rsp_valid;
    assign rsp_instr[g] = bus.rsp_instr;
    assign rsp_fault[g] = bus.rsp_fault;
    imem_fetch #(.DEPTH_BYTES(256), .LATENCY(g == 2 ? 2 : 1), .BIG_ENDIAN(g == 1 ? 0 : 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data)
    );
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic prog(input logic [31:0] a, input logic [7:0] b);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = b;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask
  task automatic fetch(input int g, input logic [31:0] a, input logic [31:0] instr, input logic fault);
    bit ok = 0;
    exp_q.push_back('{dut: 2'(g), instr: instr, fault: fault});
    req_valid[g] = 1'b1;
    req_addr[g] = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready[g];
    end
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout: dut %0d addr %h never accepted, required req_ready=1", g, a);
    end
    @(posedge clk);
    #1 req_valid[g] = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  // response monitor: pops on handshake, compares the head entry while stalled too
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rsp_valid[g]) begin
        nvec++;
        if (exp_q.size() == 0 || exp_q[0].dut != 2'(g)) begin
          nfail++;
          $display("FAIL rsp%0d_unexpected: got instr %h fault %b, required no response", g, rsp_instr[g], rsp_fault[g]);
        end else begin
          if ({rsp_instr[g], rsp_fault[g]} !== {exp_q[0].instr, exp_q[0].fault}) begin
            nfail++;
            $display("FAIL rsp%0d_data: got instr %h fault %b, required instr %h fault %b", g, rsp_instr[g], rsp_fault[g], exp_q[0].instr, exp_q[0].fault);
          end
          if (rsp_ready[g]) void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    for (int g = 0; g < 3; g++) begin
      req_valid[g] = 1'b0;
      req_addr[g] = '0;
      rsp_ready[g] = 1'b1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_instr", rsp_instr[2], 32'd0);
    chk("reset_req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    prog(0, 8'h01);
    rst = 1'b0;
    prog(1, 8'h4B); prog(2, 8'h48); prog(3, 8'h22);
    prog(4, 8'h8C); prog(5, 8'h4A); prog(6, 8'h00); prog(7, 8'h04);
    prog(8, 8'h00); prog(9, 8'h00); prog(10, 8'h00); prog(11, 8'h00);
    prog(252, 8'h11); prog(253, 8'h22); prog(254, 8'h33); prog(255, 8'h44);
    prog(256, 8'hEE);
    fetch(0, 0, 32'h014B4822, 1'b0);
    @(negedge clk);
    chk("l1_latency_valid", 32'(rsp_valid[0]), 32'd1);
    @(posedge clk);
    #1;
    fetch(0, 2, 32'h0, 1'b1);
    fetch(0, 256, 32'h0, 1'b1);
    fetch(0, 252, 32'h11223344, 1'b0);
    fetch(0, 253, 32'h0, 1'b1);
    fetch(0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    fetch(0, 0, 32'h014B4822, 1'b0);
    fetch(0, 4, 32'h8C4A0004, 1'b0);
    prog(4, 8'hFF);
    fetch(0, 4, 32'hFF4A0004, 1'b0);
    drain();
    prog_we = 1'b1;
    prog_addr = 8;
    prog_data = 8'h55;
    req_valid[0] = 1'b1;
    req_addr[0] = 0;
    @(negedge clk);
    chk("prog_blocks_req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    req_valid[0] = 1'b0;
    fetch(0, 8, 32'h55000000, 1'b0);
    drain();
    fetch(1, 0, 32'h22484B01, 1'b0);
    fetch(1, 4, 32'h04004AFF, 1'b0);
    drain();
    fetch(2, 252, 32'h11223344, 1'b0);
    @(negedge clk);
    chk("l2_latency_cycle1", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    chk("l2_latency_cycle2", 32'(rsp_valid[2]), 32'd1);
    drain();
    rsp_ready[2] = 1'b0;
    fetch(2, 0, 32'h014B4822, 1'b0);
    fetch(2, 4, 32'hFF4A0004, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready[2]), 32'd0);
      chk("stall_rsp_instr", rsp_instr[2], 32'h014B4822);
    end
    @(posedge clk);
    #1 rsp_ready[2] = 1'b1;
    drain();
    rsp_ready[0] = 1'b0;
    fetch(0, 4, 32'hFF4A0004, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("flush_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("flush_rsp_word", {rsp_instr[0][30:0], rsp_fault[0]}, 32'd0);
    end
    chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    fetch(0, 0, 32'h014B4822, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH_BYTES, default 256: memory size in bytes; must be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter LATENCY, default 1: request-to-response cycles; legal values are 1 and 2.
REQ-003 The block SHALL have parameter BIG_ENDIAN, default 1: if 1, byte at addr goes to instr[31:24]; if 0, it goes to instr[7:0].
REQ-004 Port clk, input, 1: single clock, all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1: fetch request present.
REQ-007 Port req_ready, output, 1: fetch request accepted this cycle when high together with req_valid.
REQ-008 Port req_addr, input, 32: byte address of the fetch.
REQ-009 Port rsp_valid, output, 1: response present.
REQ-010 Port rsp_ready, input, 1: consumer accepts the response.
REQ-011 Port rsp_instr, output, 32: fetched instruction word.
REQ-012 Port rsp_fault, output, 1: the request was misaligned or out of range.
REQ-013 Port prog_we, input, 1: program-load byte write strobe.
REQ-014 Port prog_addr, input, 32: program-load byte address.
REQ-015 Port prog_data, input, 8: program-load byte.

Function
REQ-016 A fetch SHALL be accepted when req_valid and req_ready are both high; the four bytes addr..addr+3 are sampled from memory in the accept cycle.
REQ-017 An accepted fetch SHALL produce exactly one response, with rsp_valid high, LATENCY cycles after acceptance when not stalled.
REQ-018 Responses SHALL be returned in request order, and one fetch per cycle SHALL be sustainable when rsp_ready is held high.
REQ-019 Stall: when rsp_valid=1 and rsp_ready=0, the whole pipeline SHALL hold, and rsp_instr and rsp_fault SHALL stay stable until the response is accepted.
REQ-020 req_ready SHALL equal !prog_we && !(rsp_valid && !rsp_ready && pipeline full).
REQ-021 Fault SHALL be raised when req_addr[1:0] != 0 or req_addr > DEPTH_BYTES-4; the response then has rsp_fault=1 and rsp_instr=32'h0000_0000 (NOP), and memory is not read.
REQ-022 Byte order: with BIG_ENDIAN=1, instr = {m[a],m[a+1],m[a+2],m[a+3]}; with BIG_ENDIAN=0, the byte order is reversed.
REQ-023 Address arithmetic SHALL use log2(DEPTH_BYTES)-bit indices only after the range check, so no wrap-around read is possible.
REQ-024 When prog_we=1, m[prog_addr] SHALL be written with prog_data at the clock edge; prog_addr >= DEPTH_BYTES SHALL be ignored with no error.
REQ-025 Simultaneous prog_we and req_valid: the write SHALL take effect and the fetch SHALL not be accepted (req_ready=0).
REQ-026 A write made after a fetch was accepted SHALL NOT alter that in-flight fetch's response.
REQ-027 A fetch accepted in the cycle after a write SHALL observe the written byte.

Reset
REQ-028 rst=1 SHALL clear rsp_valid, rsp_instr and rsp_fault to 0 and flush all in-flight fetches, dropping them with no response.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 req_ready SHALL be 0 during the rst=1 cycle and SHALL follow REQ-020 from the next cycle.
REQ-031 A prog_we asserted during reset SHALL still write memory.

Structure
REQ-032 Package imem_pkg SHALL hold INSTR_W=32, BYTE_W=8, IMEM_NOP=32'h0000_0000, and the typedef of the response struct {instr, fault}.
REQ-033 One sub-module, imem_resp_stage, SHALL implement a single stallable valid/data register and be instantiated LATENCY times.

Verification
REQ-034 Load bytes 01 4B 48 22 at addresses 0..3, fetch addr 0 with LATENCY=1 -> rsp_valid next cycle, rsp_instr=0x014B4822, rsp_fault=0.
REQ-035 Same bytes with BIG_ENDIAN=0, fetch addr 0 -> rsp_instr=0x22484B01.
REQ-036 Fetch addr 2, then addr 256 (DEPTH_BYTES=256) -> two responses, each with rsp_fault=1 and rsp_instr=0.
REQ-037 LATENCY=2, back-to-back fetches of addr 0 and 4 with rsp_ready=0 for 3 cycles -> req_ready drops, rsp_instr holds 0x014B4822, then addr 4 data follows in order with no loss or duplicate.
REQ-038 Fetch addr 4 accepted, then write 0xFF to byte 4 in the next cycle -> response shows old data; re-fetch addr 4 -> MSB is 0xFF; a simultaneous prog_we and req_valid -> req_ready=0.
REQ-039 Assert rst with a fetch in flight -> no rsp_valid afterwards, all outputs 0, memory retains 0x014B4822 at addr 0.
